// File: rtl/mem32_byte_streamer_pkg.sv
// Shared definitions for the mem32 word buffer, the byte streamer and the stream sink.
package mem32_byte_streamer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_SEND  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_FIN   = 3'd5,
        ST_REARM = 3'd6
    } state_t;

endpackage

// File: rtl/mem32_byte_streamer_if.sv
// Bundle of the buffer read port, the byte stream and the status strobes.
// master = the streamer, slave = the buffer/sink side.
import mem32_byte_streamer_pkg::*;

interface mem32_byte_streamer_if #(
    parameter int ADDR_W = 2
);
    logic              mem_valid;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_data;
    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              abort;

    modport master (
        input  mem_valid, mem_data, m_ready,
        output mem_rd, mem_addr, m_data, m_valid, m_last, busy, done, abort
    );

    modport slave (
        output mem_valid, mem_data, m_ready,
        input  mem_rd, mem_addr, m_data, m_valid, m_last, busy, done, abort
    );
endinterface

// File: rtl/mem32_byte_streamer_xor_csum_acc.sv
// Running 8-bit XOR accumulator: clr wins over en, result is registered.
import mem32_byte_streamer_pkg::*;

module xor_csum_acc (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] acc
);
    logic [BYTE_W-1:0] acc_reg;
    logic [BYTE_W-1:0] acc_next;

    // Per-bit next value: cleared, toggled by the incoming bit, or held.
    generate
        for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_bit
            assign acc_next[gi] = clr ? 1'b0 : (en ? (acc_reg[gi] ^ din[gi]) : acc_reg[gi]);
        end
    endgenerate

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/mem32_byte_streamer.sv
// Reads a filled word buffer back byte by byte and emits it on a valid/ready
// byte stream, optionally followed by an XOR checksum byte. One frame is sent
// per buffer fill; a buffer that empties mid-frame aborts the frame.
import mem32_byte_streamer_pkg::*;

module mem32_byte_streamer #(
    parameter int NUM_BYTES = 4,
    parameter int ADDR_W    = 2,
    parameter int ADD_CSUM  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem32_byte_streamer_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              drop_reg;     // buffer went empty while a byte was on the stream
    logic              mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [BYTE_W-1:0] m_data_reg;
    logic              m_valid_reg;
    logic              m_last_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              abort_reg;

    logic              csum_clr;
    logic              csum_en;
    logic [BYTE_W-1:0] csum_acc;
    logic              hs;

    assign hs       = m_valid_reg & bus.m_ready;
    assign csum_clr = (state_reg == ST_IDLE) && bus.mem_valid;
    assign csum_en  = (state_reg == ST_CAP) && bus.mem_valid;

    xor_csum_acc u_csum (
        .clk (clk),
        .rst (rst),
        .clr (csum_clr),
        .en  (csum_en),
        .din (bus.mem_data),
        .acc (csum_acc)
    );

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            drop_reg     <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_addr_reg <= '0;
            m_data_reg   <= '0;
            m_valid_reg  <= 1'b0;
            m_last_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.mem_valid) begin
                        state_reg    <= ST_RD;
                        busy_reg     <= 1'b1;
                        idx_reg      <= '0;
                        drop_reg     <= 1'b0;
                        mem_rd_reg   <= 1'b1;
                        mem_addr_reg <= '0;
                    end
                end
                ST_RD: begin
                    mem_rd_reg <= 1'b0;
                    if (!bus.mem_valid) begin
                        abort_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    if (!bus.mem_valid) begin
                        abort_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        m_data_reg  <= bus.mem_data;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= (ADD_CSUM == 0) && (idx_reg == LAST_IDX);
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bus.mem_valid) begin
                        drop_reg <= 1'b1;
                    end
                    if (hs) begin
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                        if (drop_reg || !bus.mem_valid) begin
                            abort_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else if (idx_reg < LAST_IDX) begin
                            idx_reg      <= idx_reg + 1'b1;
                            mem_rd_reg   <= 1'b1;
                            mem_addr_reg <= idx_reg + 1'b1;
                            state_reg    <= ST_RD;
                        end else if (ADD_CSUM != 0) begin
                            m_data_reg  <= csum_acc;
                            m_valid_reg <= 1'b1;
                            m_last_reg  <= 1'b1;
                            state_reg   <= ST_CSUM;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end
                    end
                end
                ST_CSUM: begin
                    if (!bus.mem_valid) begin
                        drop_reg <= 1'b1;
                    end
                    if (hs) begin
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                        if (drop_reg || !bus.mem_valid) begin
                            abort_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state_reg <= ST_REARM;
                end
                ST_REARM: begin
                    // A buffer that stays full must not be streamed twice.
                    if (!bus.mem_valid) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd   = mem_rd_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.m_data   = m_data_reg;
    assign bus.m_valid  = m_valid_reg;
    assign bus.m_last   = m_last_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.abort    = abort_reg;
endmodule

// File: tb/tb_mem32_byte_streamer.sv
// Directed bench: one streamer with checksum (bc) and one without (bn),
// each fed by a small registered-read model of the word buffer.
module tb_mem32_byte_streamer;
    logic clk;
    logic rst;
    logic [31:0] word_reg;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    mem32_byte_streamer_if #(.ADDR_W(2)) bc ();
    mem32_byte_streamer_if #(.ADDR_W(2)) bn ();

    mem32_byte_streamer #(.NUM_BYTES(4), .ADDR_W(2), .ADD_CSUM(1)) dut_c (
        .clk (clk), .rst (rst), .bus (bc.master)
    );
    mem32_byte_streamer #(.NUM_BYTES(4), .ADDR_W(2), .ADD_CSUM(0)) dut_n (
        .clk (clk), .rst (rst), .bus (bn.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer models: data appears one cycle after the read strobe.
    always @(posedge clk) if (bc.mem_rd) bc.mem_data <= word_reg[8*bc.mem_addr +: 8];
    always @(posedge clk) if (bn.mem_rd) bn.mem_data <= word_reg[8*bn.mem_addr +: 8];

    // Monitors, sampled mid-cycle.
    logic [7:0] by_c [0:63];
    logic       la_c [0:63];
    logic [1:0] ad_c [0:63];
    int nb_c = 0, nr_c = 0, nd_c = 0, na_c = 0;
    logic [7:0] by_n [0:63];
    logic       la_n [0:63];
    int nb_n = 0, nr_n = 0, nd_n = 0, na_n = 0;

    always @(negedge clk) begin
        if (bc.m_valid && bc.m_ready) begin
            if (nb_c < 64) begin
                by_c[nb_c] <= bc.m_data;
                la_c[nb_c] <= bc.m_last;
            end
            nb_c <= nb_c + 1;
        end
        if (bc.mem_rd) begin
            if (nr_c < 64) ad_c[nr_c] <= bc.mem_addr;
            nr_c <= nr_c + 1;
        end
        if (bc.done)  nd_c <= nd_c + 1;
        if (bc.abort) na_c <= na_c + 1;
    end

    always @(negedge clk) begin
        if (bn.m_valid && bn.m_ready) begin
            if (nb_n < 64) begin
                by_n[nb_n] <= bn.m_data;
                la_n[nb_n] <= bn.m_last;
            end
            nb_n <= nb_n + 1;
        end
        if (bn.mem_rd) nr_n <= nr_n + 1;
        if (bn.done)   nd_n <= nd_n + 1;
        if (bn.abort)  na_n <= na_n + 1;
    end

    logic [7:0] exp_a [0:4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mvalid(input bit sel, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = sel ? bn.m_valid : bc.m_valid;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_end(input bit sel, input int budget, input string tag);
        int d0 = sel ? nd_n : nd_c;
        int a0 = sel ? na_n : na_c;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = sel ? ((nd_n != d0) || (na_n != a0)) : ((nd_c != d0) || (na_c != a0));
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Full A1,B2,C3,D4,04 frame on bc starting at the given monitor indices.
    task automatic check_frame_c(input int bbase, input int rbase, input string tag);
        chk({tag, " nbytes"}, 32'(nb_c - bbase), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s byte%0d", tag, i), 32'(by_c[bbase+i]), 32'(exp_a[i]));
            chk($sformatf("%s last%0d", tag, i), 32'(la_c[bbase+i]), 32'(i == 4));
        end
        chk({tag, " nrd"}, 32'(nr_c - rbase), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s addr%0d", tag, i), 32'(ad_c[rbase+i]), 32'(i));
        end
    endtask

    initial begin
        int bb, rb, db, ab;
        bit seen;
        rst = 1'b1;
        word_reg = 32'hD4C3B2A1;
        bc.mem_valid = 1'b0; bc.m_ready = 1'b0; bc.mem_data = '0;
        bn.mem_valid = 1'b0; bn.m_ready = 1'b0; bn.mem_data = '0;

        // Reset state
        tick();
        chk("rst m_valid", 32'(bc.m_valid), 32'd0);
        chk("rst m_data", 32'(bc.m_data), 32'd0);
        chk("rst m_last", 32'(bc.m_last), 32'd0);
        chk("rst busy", 32'(bc.busy), 32'd0);
        chk("rst done", 32'(bc.done), 32'd0);
        chk("rst abort", 32'(bc.abort), 32'd0);
        chk("rst mem_rd", 32'(bc.mem_rd), 32'd0);
        chk("rst mem_addr", 32'(bc.mem_addr), 32'd0);
        chk("rst n busy", 32'(bn.busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle busy", 32'(bc.busy), 32'd0);

        // 1: full frame with checksum, latency of first byte
        bb = nb_c; rb = nr_c; db = nd_c; ab = na_c;
        bc.m_ready = 1'b1;
        bc.mem_valid = 1'b1;
        tick();
        chk("t1 rd strobe", 32'(bc.mem_rd), 32'd1);
        chk("t1 rd addr", 32'(bc.mem_addr), 32'd0);
        chk("t1 busy", 32'(bc.busy), 32'd1);
        chk("t1 early valid", 32'(bc.m_valid), 32'd0);
        tick();
        chk("t1 cap rd low", 32'(bc.mem_rd), 32'd0);
        chk("t1 cap valid", 32'(bc.m_valid), 32'd0);
        tick();
        chk("t1 first valid", 32'(bc.m_valid), 32'd1);
        chk("t1 first data", 32'(bc.m_data), 32'hA1);
        wait_end(1'b0, 40, "t1 end");
        check_frame_c(bb, rb, "t1");
        chk("t1 done", 32'(nd_c - db), 32'd1);
        chk("t1 abort", 32'(na_c - ab), 32'd0);

        // 4b: buffer stays full after done -> no second frame
        rb = nr_c;
        for (int i = 0; i < 10; i++) tick();
        chk("rearm nrd", 32'(nr_c - rb), 32'd0);
        chk("rearm busy", 32'(bc.busy), 32'd1);
        chk("rearm valid", 32'(bc.m_valid), 32'd0);
        chk("rearm done", 32'(nd_c - db), 32'd1);
        bc.mem_valid = 1'b0;
        tick();
        tick();
        chk("rearm idle", 32'(bc.busy), 32'd0);

        // 2: no checksum, all-ones word
        word_reg = 32'hFFFFFFFF;
        bb = nb_n; db = nd_n;
        bn.m_ready = 1'b1;
        bn.mem_valid = 1'b1;
        wait_end(1'b1, 40, "t2 end");
        chk("t2 nbytes", 32'(nb_n - bb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2 byte%0d", i), 32'(by_n[bb+i]), 32'hFF);
            chk($sformatf("t2 last%0d", i), 32'(la_n[bb+i]), 32'(i == 3));
        end
        chk("t2 done", 32'(nd_n - db), 32'd1);
        chk("t2 abort", 32'(na_n), 32'd0);
        bn.mem_valid = 1'b0;
        tick();
        tick();

        // 3: 5-cycle stall on B2
        word_reg = 32'hD4C3B2A1;
        bb = nb_c; rb = nr_c;
        bc.m_ready = 1'b0;
        bc.mem_valid = 1'b1;
        wait_mvalid(1'b0, 10, "t3 A1 wait");
        bc.m_ready = 1'b1;
        tick();
        bc.m_ready = 1'b0;
        wait_mvalid(1'b0, 10, "t3 B2 wait");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3 stall valid%0d", i), 32'(bc.m_valid), 32'd1);
            chk($sformatf("t3 stall data%0d", i), 32'(bc.m_data), 32'hB2);
            tick();
        end
        chk("t3 stall nrd", 32'(nr_c - rb), 32'd2);
        bc.m_ready = 1'b1;
        wait_end(1'b0, 40, "t3 end");
        check_frame_c(bb, rb, "t3");
        bc.mem_valid = 1'b0;
        tick();
        tick();

        // 4a: buffer empties during RD of byte 2
        bb = nb_c; rb = nr_c; db = nd_c; ab = na_c;
        bc.mem_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = bc.mem_rd && (bc.mem_addr == 2'd2);
        end
        chk("t4 reach rd2", 32'(seen), 32'd1);
        bc.mem_valid = 1'b0;
        tick();
        chk("t4 abort", 32'(bc.abort), 32'd1);
        chk("t4 valid", 32'(bc.m_valid), 32'd0);
        chk("t4 busy", 32'(bc.busy), 32'd0);
        tick();
        chk("t4 abort pulse", 32'(bc.abort), 32'd0);
        chk("t4 nbytes", 32'(nb_c - bb), 32'd2);
        chk("t4 nrd", 32'(nr_c - rb), 32'd3);
        chk("t4 no done", 32'(nd_c - db), 32'd0);
        chk("t4 abort count", 32'(na_c - ab), 32'd1);

        // 5: asynchronous reset mid-SEND, then a clean restart
        bc.m_ready = 1'b0;
        bc.mem_valid = 1'b1;
        wait_mvalid(1'b0, 10, "t5 send wait");
        #2;
        rst = 1'b1;
        #1;
        chk("t5 valid", 32'(bc.m_valid), 32'd0);
        chk("t5 data", 32'(bc.m_data), 32'd0);
        chk("t5 busy", 32'(bc.busy), 32'd0);
        chk("t5 last", 32'(bc.m_last), 32'd0);
        chk("t5 rd", 32'(bc.mem_rd), 32'd0);
        tick();
        bb = nb_c; rb = nr_c;
        rst = 1'b0;
        bc.m_ready = 1'b1;
        wait_end(1'b0, 40, "t5 end");
        check_frame_c(bb, rb, "t5");
        bc.mem_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
